// File: rtl/kyber_pack_pkg.sv
// Shared definitions for the pack_sched word packer: FSM state encoding and
// the requester-index width helper.
package kyber_pack_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int sw_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first asserted
// request found when searching upward from ptr, wrapping at NUM_REQ.
module rr_arbiter
  import kyber_pack_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int SW      = sw_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [SW-1:0] idx;
  logic          found;

  // NOTE: every signal driven here gets a default before the loop, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = SW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pack_sched.sv
// Packs N = OUTPUT_WIDTH/INPUT_WIDTH words from one round-robin-granted
// requester into a single output word. Define PACK_SCHED_TIMEOUT_EN to abort stalled fills.
module pack_sched
  import kyber_pack_pkg::*;
#(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 64,
  parameter int NUM_REQ      = 2,
  parameter int TIMEOUT      = 16
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [OUTPUT_WIDTH-1:0]        o_out_data,
  output logic [sw_width(NUM_REQ)-1:0]   o_out_src,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic                           o_abort
);

  localparam int N  = OUTPUT_WIDTH / INPUT_WIDTH;
  localparam int SW = sw_width(NUM_REQ);
  localparam int BW = sw_width(N);

  if ((OUTPUT_WIDTH % INPUT_WIDTH) != 0 || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1)
  begin : g_param_check
    $error("pack_sched: illegal parameter combination");
  end

  logic [1:0]             state;
  logic [SW-1:0]          ptr;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     arb_grant;
  logic [SW-1:0]          arb_idx;
  logic [BW-1:0]          beat;
  logic [INPUT_WIDTH-1:0] word;
  logic [SW-1:0]          next_ptr;
  logic                   xfer;
  logic                   timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SW      (SW)
  ) u_arb (
    .req   (i_req_valid),
    .ptr   (ptr),
    .grant (arb_grant)
  );

  // Ready and valid follow the state alone, so reset clears them at once.
  assign o_req_ready = (state == ST_FILL) ? grant : '0;
  assign o_out_valid = (state == ST_HOLD);
  assign xfer        = |(i_req_valid & o_req_ready);
  assign next_ptr    = (o_out_src == SW'(NUM_REQ - 1)) ? '0 : o_out_src + SW'(1);

  always_comb begin
    arb_idx = '0;
    word    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) arb_idx = SW'(k);
      if (grant[k])     word    = word | i_req_data[k*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order statements are evaluated in.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      grant      <= '0;
      beat       <= '0;
      o_out_data <= '0;
      o_out_src  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|i_req_valid) begin
            grant     <= arb_grant;
            o_out_src <= arb_idx;
            beat      <= '0;
            state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (xfer) begin
            // Earlier words migrate upward; the first ends in the top slice.
            o_out_data <= (o_out_data << INPUT_WIDTH) | OUTPUT_WIDTH'(word);
            if (beat == BW'(N - 1)) begin
              beat  <= '0;
              state <= ST_HOLD;
            end else begin
              beat <= beat + BW'(1);
            end
          end else if (timeout_hit) begin
            o_out_data <= '0;
            beat       <= '0;
            ptr        <= next_ptr;
            state      <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (i_out_ready) begin
            ptr   <= next_ptr;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PACK_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall;

  assign timeout_hit = (state == ST_FILL) && !xfer && (stall == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall   <= '0;
      o_abort <= 1'b0;
    end else begin
      o_abort <= timeout_hit;
      if (state != ST_FILL || xfer || timeout_hit) stall <= '0;
      else                                         stall <= stall + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_abort     = 1'b0;
`endif

endmodule

// File: doc/pack_sched.md
PACK_SCHED -- requirements
Module: pack_sched

Interface
- REQ-001: Parameter INPUT_WIDTH, default 32, SHALL set the requester word width in bits.
- REQ-002: Parameter OUTPUT_WIDTH, default 64, SHALL set the packed word width; it SHALL be an integer multiple of INPUT_WIDTH, and N = OUTPUT_WIDTH/INPUT_WIDTH.
- REQ-003: Parameter NUM_REQ, default 2, range 2..8, SHALL set the number of requesters; SW = clog2(NUM_REQ).
- REQ-004: Parameter TIMEOUT, default 16, SHALL set the stall limit in cycles; it is used only when the timeout feature is compiled in.
- REQ-005: i_clk  input  1  single clock; all logic on its rising edge.
- REQ-006: i_reset_n  input  1  reset, asynchronous, active-low.
- REQ-007: i_req_valid  input  NUM_REQ  per-requester word valid.
- REQ-008: i_req_data  input  NUM_REQ*INPUT_WIDTH  requester k in slice [k*INPUT_WIDTH +: INPUT_WIDTH].
- REQ-009: o_req_ready  output  NUM_REQ  per-requester word accept.
- REQ-010: o_out_data  output  OUTPUT_WIDTH  packed word.
- REQ-011: o_out_src  output  SW  index of the requester that supplied o_out_data.
- REQ-012: o_out_valid  output  1  packed word available.
- REQ-013: i_out_ready  input  1  downstream accept.
- REQ-014: o_abort  output  1  one-cycle pulse when a partial word is discarded.

Function
- REQ-015: A word transfers on requester k in a cycle where i_req_valid[k] and o_req_ready[k] are both 1; a packed word transfers in a cycle where o_out_valid and i_out_ready are both 1.
- REQ-016: The FSM SHALL have three states: IDLE, FILL and HOLD.
- REQ-017: In IDLE with any valid asserted, the block SHALL grant round-robin, starting the search at index ptr, and go to FILL next cycle; o_req_ready SHALL be 0 in IDLE.
- REQ-018: In FILL, o_req_ready SHALL be 1 only for the granted requester, and all other requesters SHALL see 0.
- REQ-019: Each accepted word SHALL shift in, first word ending in the most significant INPUT_WIDTH bits; the Nth word completes the packed word.
- REQ-020: On the Nth transfer the block SHALL move to HOLD, with o_out_valid=1 from the next cycle and o_out_data/o_out_src stable while in HOLD.
- REQ-021: In HOLD, i_out_ready=1 SHALL cause a return to IDLE and set ptr = (grant+1) mod NUM_REQ; o_req_ready SHALL be 0 throughout HOLD.
- REQ-022: Minimum spacing from grant to the next grant SHALL be N+2 cycles.
- REQ-023: A deasserted valid during FILL SHALL stall without losing the partial word or the beat count.
- REQ-024: Grant SHALL be held for all N beats; a newly valid requester SHALL never preempt the granted one.
- REQ-025: When N=1, FILL SHALL last exactly one transfer.

Reset
- REQ-026: Asserting i_reset_n low SHALL immediately set: state IDLE, ptr 0, beat count 0, o_out_data 0, o_out_src 0, o_out_valid 0, o_req_ready 0, o_abort 0.
- REQ-027: Reset mid-FILL or mid-HOLD SHALL discard all data with no o_abort pulse.

Configuration
- REQ-028: With PACK_SCHED_TIMEOUT_EN defined, TIMEOUT consecutive FILL cycles without a transfer SHALL discard the partial word, pulse o_abort for one cycle, advance ptr past the grant and return to IDLE.
- REQ-029: Without PACK_SCHED_TIMEOUT_EN, FILL SHALL wait indefinitely and o_abort SHALL be tied to 0.

Structure
- REQ-030: Package kyber_pack_pkg SHALL hold the FSM state encoding and the clog2-based SW width function.
- REQ-031: A sub-module rr_arbiter (request vector, ptr in, one-hot grant out, combinational) SHALL implement grant selection.

Verification
- REQ-032: NUM_REQ=2, N=2; req0 sends 0x11111111, 0x22222222 -> o_out_data=0x1111111122222222, o_out_src=0, o_out_valid 3 cycles after grant.
- REQ-033: Both requesters valid continuously -> packed words alternate src 0,1,0,1 and never mix words from different sources.
- REQ-034: i_out_ready held 0 for 5 cycles in HOLD -> o_out_valid and o_out_data stay stable, and o_req_ready stays 0.
- REQ-035: req1 drops valid after 1 beat for 3 cycles, then resumes -> the packed word is correct with no other grant issued.
- REQ-036: PACK_SCHED_TIMEOUT_EN, TIMEOUT=16, granted requester silent for 16 cycles -> o_abort pulse, next grant goes to the other requester, and no o_out_valid occurs.
- REQ-037: i_reset_n pulsed low mid-FILL -> all outputs are 0 immediately, and the next grant goes to requester 0.
